// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage and its externally connected ALU:
// opcodes, ALU selects, CCR bit positions and the stage FSM encoding.
package exec_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_RETIRE = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h8;
  localparam logic [3:0] OP_LDB = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CLC = 4'hB;

  localparam logic [2:0] ALU_SEL_NONE = 3'b000;
  localparam logic [2:0] ALU_SEL_SUB  = 3'b001;

  localparam int unsigned CCR_N = 3;
  localparam int unsigned CCR_Z = 2;
  localparam int unsigned CCR_V = 1;
  localparam int unsigned CCR_C = 0;

  // ALU operation requested by an opcode while it is in EXEC.
  function automatic logic [2:0] alu_sel_for(input logic [3:0] op);
    if (!op[3])
      return op[2:0];
    else if (op == OP_CMP)
      return ALU_SEL_SUB;
    else
      return ALU_SEL_NONE;
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return op[3] && op[2];
  endfunction

endpackage

// File: rtl/exec_stage.sv
// Three-state execute stage: accepts one command, drives the external ALU for
// one cycle, then retires it by updating A/B/CCR and pulsing DONE (and ERR).
module exec_stage
  import exec_stage_pkg::*;
#(
  parameter logic [3:0] CCR_RESET = 4'h0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [3:0] CMD_OP,
  input  logic       CMD_DEST,
  input  logic [7:0] CMD_IMM,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [2:0] ALU_SEL,
  input  logic [7:0] ALU_RESULT,
  input  logic [3:0] ALU_NZVC,
  output logic [7:0] REG_A,
  output logic [7:0] REG_B,
  output logic [3:0] CCR,
  output logic       DONE,
  output logic       ERR
);

  state_t     state;
  logic [3:0] op_q;
  logic       dest_q;
  logic [7:0] imm_q;

  assign CMD_READY = (state == ST_IDLE) && !RESET;
  assign ALU_A     = REG_A;
  assign ALU_B     = REG_B;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      dest_q  <= 1'b0;
      imm_q   <= '0;
      REG_A   <= '0;
      REG_B   <= '0;
      CCR     <= CCR_RESET;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      ALU_SEL <= ALU_SEL_NONE;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // READY is simply "IDLE and not in reset", so VALID alone completes the handshake here.
          if (CMD_VALID) begin
            op_q    <= CMD_OP;
            dest_q  <= CMD_DEST;
            imm_q   <= CMD_IMM;
            ALU_SEL <= alu_sel_for(CMD_OP);
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          ALU_SEL <= ALU_SEL_NONE;
          DONE    <= 1'b1;
          ERR     <= is_reserved(op_q);
          state   <= ST_RETIRE;
          if (!op_q[3]) begin
            if (dest_q)
              REG_B <= ALU_RESULT;
            else
              REG_A <= ALU_RESULT;
            CCR <= ALU_NZVC;
          end else begin
            case (op_q)
              OP_LDA: begin
                REG_A      <= imm_q;
                CCR[CCR_N] <= imm_q[7];
                CCR[CCR_Z] <= (imm_q == 8'h00);
              end
              OP_LDB: begin
                REG_B      <= imm_q;
                CCR[CCR_N] <= imm_q[7];
                CCR[CCR_Z] <= (imm_q == 8'h00);
              end
              OP_CMP:  CCR <= ALU_NZVC;
              OP_CLC:  CCR <= '0;
              default: ;
            endcase
          end
        end
        ST_RETIRE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Randomized self-checking bench for exec_stage with a behavioural ALU and
// an architectural reference model of A, B and CCR.
module tb_exec_stage;

  localparam logic [3:0] RST_CCR = 4'hA;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic       cmd_dest;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic [3:0] alu_nzvc;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic [3:0] ccr;
  logic       done;
  logic       err;

  int unsigned n_cmp;
  int unsigned n_bad;

  logic [7:0] ea;
  logic [7:0] eb;
  logic [3:0] eccr;

  exec_stage #(.CCR_RESET(RST_CCR)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .CMD_VALID  (cmd_valid),
    .CMD_READY  (cmd_ready),
    .CMD_OP     (cmd_op),
    .CMD_DEST   (cmd_dest),
    .CMD_IMM    (cmd_imm),
    .ALU_A      (alu_a),
    .ALU_B      (alu_b),
    .ALU_SEL    (alu_sel),
    .ALU_RESULT (alu_result),
    .ALU_NZVC   (alu_nzvc),
    .REG_A      (reg_a),
    .REG_B      (reg_b),
    .CCR        (ccr),
    .DONE       (done),
    .ERR        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {N,Z,V,C, result}.
  function automatic logic [11:0] alu_fn(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    int r;
    logic [7:0] res;
    logic v, c;
    v = 1'b0; c = 1'b0;
    case (sel)
      3'd0: begin r = int'(a) + int'(b); res = r[7:0]; c = r > 255;
              v = (a[7] == b[7]) && (res[7] != a[7]); end
      3'd1: begin r = int'(a) - int'(b); res = r[7:0]; c = a < b;
              v = (a[7] != b[7]) && (res[7] != a[7]); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: begin res = {a[6:0], 1'b0}; c = a[7]; end
      3'd6: begin res = {1'b0, a[7:1]}; c = a[0]; end
      default: begin r = int'(b) - 1; res = r[7:0]; c = (b == 8'h00); v = (b == 8'h80); end
    endcase
    return {res[7], res == 8'h00, v, c, res};
  endfunction

  logic [11:0] alu_out;
  always_comb begin
    alu_out    = alu_fn(alu_sel, alu_a, alu_b);
    alu_nzvc   = alu_out[11:8];
    alu_result = alu_out[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_sel(input logic [3:0] op);
    if (op < 4'h8) return op[2:0];
    if (op == 4'hA) return 3'b001;
    return 3'b000;
  endfunction

  // Architectural effect of one retired command on A, B and CCR.
  task automatic model_apply(input logic [3:0] op, input logic dest, input logic [7:0] imm);
    logic [11:0] o;
    if (op < 4'h8) begin
      o = alu_fn(op[2:0], ea, eb);
      if (dest) eb = o[7:0]; else ea = o[7:0];
      eccr = o[11:8];
    end else if (op == 4'h8) begin
      ea = imm; eccr = {imm[7], imm == 8'h00, eccr[1:0]};
    end else if (op == 4'h9) begin
      eb = imm; eccr = {imm[7], imm == 8'h00, eccr[1:0]};
    end else if (op == 4'hA) begin
      o = alu_fn(3'b001, ea, eb);
      eccr = o[11:8];
    end else if (op == 4'hB) begin
      eccr = 4'h0;
    end
  endtask

  task automatic wait_ready();
    int unsigned w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic dest, input logic [7:0] imm);
    wait_ready();
    cmd_op = op; cmd_dest = dest; cmd_imm = imm; cmd_valid = 1'b1;
    @(negedge clk);
    // Scramble inputs after acceptance; the captured command must be used.
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom); cmd_dest = 1'($urandom); cmd_imm = 8'($urandom);
    check("exec_done", done, 0);
    check("exec_ready", cmd_ready, 0);
    check("exec_sel", alu_sel, exp_sel(op));
    model_apply(op, dest, imm);
    @(negedge clk);
    check("ret_done", done, 1);
    check("ret_err", err, op >= 4'hC);
    check("ret_sel", alu_sel, 0);
    check("ret_ready", cmd_ready, 0);
    check("reg_a", reg_a, ea);
    check("reg_b", reg_b, eb);
    check("ccr", ccr, eccr);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_err", err, 0);
    check("idle_ready", cmd_ready, 1);
  endtask

  initial begin
    logic [9:0] acc_mask;
    int unsigned acc;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dest = 1'b0; cmd_imm = '0;
    ea = '0; eb = '0; eccr = RST_CCR;
    repeat (2) @(negedge clk);
    check("rst_a", reg_a, 0);
    check("rst_b", reg_b, 0);
    check("rst_ccr", ccr, RST_CCR);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_sel", alu_sel, 0);
    check("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);

    run_cmd(4'h8, 1'b0, 8'h7F);
    run_cmd(4'h9, 1'b0, 8'h01);
    run_cmd(4'h0, 1'b0, 8'h00);
    check("add_a", reg_a, 8'h80);
    check("add_ccr", ccr, 4'b1010);

    run_cmd(4'h8, 1'b0, 8'h05);
    run_cmd(4'h9, 1'b0, 8'h05);
    run_cmd(4'hA, 1'b0, 8'h00);
    check("cmp_ccr", ccr, 4'b0100);
    check("cmp_a", reg_a, 8'h05);
    check("cmp_b", reg_b, 8'h05);

    run_cmd(4'h9, 1'b0, 8'h00);
    run_cmd(4'h7, 1'b1, 8'h00);
    check("dec_b", reg_b, 8'hFF);
    check("dec_ccr", ccr, 4'b1001);

    run_cmd(4'hD, 1'b0, 8'h33);

    // VALID held for 10 cycles: acceptances only every third edge.
    wait_ready();
    cmd_op = 4'hB; cmd_dest = 1'b0; cmd_imm = 8'h00; cmd_valid = 1'b1;
    acc = 0; acc_mask = '0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready && cmd_valid) begin
        acc++;
        acc_mask[i] = 1'b1;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("stream_count", acc, 4);
    check("stream_cycles", acc_mask, 10'b10_0100_1001);
    repeat (4) model_apply(4'hB, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("stream_ccr", ccr, eccr);
    check("stream_ready", cmd_ready, 1);

    // Reset during EXEC of an ADD aborts it.
    run_cmd(4'h8, 1'b0, 8'h03);
    run_cmd(4'h9, 1'b0, 8'h04);
    wait_ready();
    cmd_op = 4'h0; cmd_dest = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", done, 0);
    check("abort_a", reg_a, 0);
    check("abort_b", reg_b, 0);
    check("abort_ccr", ccr, RST_CCR);
    check("abort_ready_in_rst", cmd_ready, 0);
    rst = 1'b0;
    ea = '0; eb = '0; eccr = RST_CCR;
    @(negedge clk);
    check("abort_ready", cmd_ready, 1);
    check("abort_done2", done, 0);

    for (int k = 0; k < 40; k++)
      run_cmd(4'($urandom_range(0, 15)), 1'($urandom), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter CCR_RESET, default 4'h0: value loaded into CCR on reset.
REQ-002 SHALL have one clock, CLK; reset is synchronous and active-high, RESET.
REQ-003 Ports (name  direction  width  meaning):
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  stage can accept a command.
- CMD_OP  in  4  opcode.
- CMD_DEST  in  1  destination select: 0 = A, 1 = B.
- CMD_IMM  in  8  immediate for loads.
- ALU_A  out  8  ALU operand A.
- ALU_B  out  8  ALU operand B.
- ALU_SEL  out  3  ALU operation select.
- ALU_RESULT  in  8  ALU result.
- ALU_NZVC  in  4  ALU flags {N,Z,V,C}.
- REG_A  out  8  accumulator A.
- REG_B  out  8  accumulator B.
- CCR  out  4  condition codes {N,Z,V,C}.
- DONE  out  1  one-cycle pulse: command retired.
- ERR  out  1  one-cycle pulse with DONE: reserved opcode.

Function
REQ-004 SHALL implement FSM states IDLE, EXEC, RETIRE; transitions: IDLE->EXEC on CMD_VALID&&CMD_READY, EXEC->RETIRE always, RETIRE->IDLE always.
REQ-005 SHALL drive CMD_READY = (state==IDLE) && !RESET; handshake completes only when VALID and READY are both high at a rising edge.
REQ-006 SHALL capture CMD_OP, CMD_DEST and CMD_IMM at acceptance; input changes after acceptance SHALL have no effect.
REQ-007 SHALL drive ALU_A = REG_A and ALU_B = REG_B continuously.
REQ-008 SHALL drive ALU_SEL from the latched opcode during EXEC, and 3'b000 in IDLE and RETIRE.
REQ-009 Opcodes 4'b0sss: ALU_SEL = sss; at end of EXEC, write ALU_RESULT to A (DEST=0) or B (DEST=1), and CCR <= ALU_NZVC.
REQ-010 Opcode 4'h8 (LDA): A <= IMM; CCR.N <= IMM[7]; CCR.Z <= (IMM==0); V and C unchanged; ALU_SEL = 000.
REQ-011 Opcode 4'h9 (LDB): as LDA, targeting B.
REQ-012 Opcode 4'hA (CMP): ALU_SEL = 001; CCR <= ALU_NZVC; A and B unchanged.
REQ-013 Opcode 4'hB (CLC): CCR <= 4'h0; A and B unchanged.
REQ-014 Opcodes 4'hC..4'hF: no register or CCR change; ERR=1 in RETIRE.
REQ-015 All register and CCR writes SHALL occur on the EXEC->RETIRE edge only.
REQ-016 DONE SHALL be high exactly in RETIRE; fixed latency is acceptance edge + 2 cycles to DONE.
REQ-017 Maximum throughput is one command per 3 cycles; the next acceptance is possible on the RETIRE->IDLE edge +1 cycle.

Reset
REQ-018 RESET sampled high SHALL force state IDLE, REG_A=0, REG_B=0, CCR=CCR_RESET, DONE=0, ERR=0, ALU_SEL=000.
REQ-019 RESET asserted during EXEC or RETIRE SHALL abort the command: no register write, no DONE.
REQ-020 RESET SHALL take priority over every other event on the same edge.

Structure
REQ-021 Opcode constants, the FSM state encoding and the CCR bit indices (N=3, Z=2, V=1, C=0) SHALL live in a shared package used with the ALU.
REQ-022 SHALL NOT instantiate the ALU; the ALU is connected at the parent level. No sub-module is required.

Verification
REQ-023 LDA 0x7F, LDB 0x01, then op 0000 with DEST=0 -> REG_A=0x80, CCR=4'b1010, DONE exactly 2 cycles after acceptance.
REQ-024 LDA 0x05, LDB 0x05, CMP -> CCR=4'b0100; REG_A=0x05 and REG_B=0x05 unchanged.
REQ-025 LDB 0x00, then op 0111 with DEST=1 -> REG_B=0xFF, CCR=4'b1001.
REQ-026 CMD_VALID held high for 10 cycles -> exactly 4 acceptances (on cycles 0, 3, 6 and 9); CMD_READY low in EXEC and RETIRE.
REQ-027 Opcode 4'hD -> DONE and ERR high together for 1 cycle; REG_A, REG_B and CCR unchanged.
REQ-028 RESET asserted in EXEC of an ADD -> no DONE; registers = 0; CCR = CCR_RESET; CMD_READY high the cycle after RESET deasserts.
